pipe_ctrl_gen: RTL

// Parametrised pipeline control unit; successor of the fixed 6-stage stall controller.

---
 rtl/pipe_ctrl_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_gen.sv
// Pipeline control: per-boundary stall thermometer, sequenced flush with redirect PC,
// and a stall watchdog. Define CTRL_PERF_CNT_EN to build the 32-bit stalled-cycle counter.
module pipe_ctrl_gen #(
    parameter int NSTAGE    = 6,
    parameter int AW        = 32,
    parameter int FLUSH_CYC = 1,
    parameter int MAX_STALL = 255,
    parameter int CW        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq,
    input  logic              flush_req,
    input  logic [AW-1:0]     flush_pc,
    output logic [NSTAGE-1:0] stall,
    output logic              flush,
    output logic [AW-1:0]     new_pc,
    output logic              stall_timeout,
    output logic [31:0]       stall_cycles
);

    localparam int             FW      = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FW-1:0]  FRELOAD = FW'(FLUSH_CYC - 1);
    localparam logic [CW-1:0]  SMAX    = CW'(MAX_STALL);

    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [CW-1:0]     scnt_q, scnt_d;
    logic              tout_q, tout_d;
    logic [NSTAGE-1:0] stall_mask;
    logic              stall_any;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v >= SMAX) return SMAX;
        return v + CW'(1);
    endfunction

    // Every boundary at or below the highest requesting stage must hold.
    always_comb begin
        logic acc;
        acc        = 1'b0;
        stall_mask = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            acc           = acc | stallreq[k];
            stall_mask[k] = acc;
        end
    end

    assign flush     = (state_q == FLUSH);
    assign stall     = (rst || flush) ? '0 : stall_mask;
    assign stall_any = |stall;
    assign new_pc    = pc_q;
    assign stall_timeout = tout_q;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    fcnt_d  = FRELOAD;
                    pc_d    = flush_pc;
                end
            end
            FLUSH: begin
                // A new request while flushing restarts the window with the latest target.
                if (flush_req) begin
                    fcnt_d = FRELOAD;
                    pc_d   = flush_pc;
                end else if (fcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q - FW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        scnt_d = '0;
        tout_d = tout_q;
        if (MAX_STALL != 0 && stall_any && !flush) begin
            scnt_d = sat_inc(scnt_q);
            if (scnt_d == SMAX) tout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
            pc_q    <= '0;
            scnt_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pc_q    <= pc_d;
            scnt_q  <= scnt_d;
            tout_q  <= tout_d;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (stall_any) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign stall_cycles = perf_q;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule
